// File: rtl/prog_loader_pkg.sv
// ----------------------------------------------------------------------------
// prog_loader_pkg
//   Shared constants and the loader state type for the writable program store.
//   The other files pull these in with import prog_loader_pkg::*.
//   Contents:
//     PL_DEPTH       number of instruction words (equals 2**PL_AW)
//     PL_AW          fetch/write address width (the core's 4-bit PC)
//     PL_DW          instruction and stream byte width
//     loader_state_t loader FSM states
// ----------------------------------------------------------------------------
package prog_loader_pkg;

   localparam int PL_DEPTH = 16;
   localparam int PL_AW    = 4;
   localparam int PL_DW    = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      RUN   = 3'd3,
      ERR   = 3'd4
   } loader_state_t;

endpackage : prog_loader_pkg

// File: rtl/prog_ram.sv
// ----------------------------------------------------------------------------
// prog_ram
//   DEPTH x DW program storage. Writes are synchronous. Reads are asynchronous
//   so the core sees its instruction in the same cycle it presents the PC.
//   The whole array clears synchronously while resetn is high, so a partial
//   image never survives a reset.
//   Ports:
//     clk     in   clock
//     resetn  in   synchronous clear, active-high
//     i_we    in   write enable
//     i_waddr in   write address
//     i_wdata in   write data
//     i_raddr in   read address
//     o_rdata out  mem[i_raddr], combinational
// ----------------------------------------------------------------------------
module prog_ram
   import prog_loader_pkg::*;
#(
   parameter int DEPTH = PL_DEPTH,
   parameter int AW    = PL_AW,
   parameter int DW    = PL_DW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // No bypass: a word written at edge N appears here after edge N.
   assign o_rdata = r_mem[i_raddr];

endmodule : prog_ram

// File: rtl/prog_loader.sv
// ----------------------------------------------------------------------------
// prog_loader
//   Writable program store with a byte-stream loader, placed in front of the
//   4-bit core in place of its fixed instruction ROM. A load is DEPTH image
//   bytes followed by one checksum byte; the image is accepted when the 8-bit
//   sum of all DEPTH+1 bytes is zero. The core is held in reset until a
//   verified image is present or a run is requested from IDLE.
//   Ports:
//     clk         in   core clock
//     resetn      in   synchronous reset, active-high
//     load_start  in   pulse: begin/restart a load (wins over everything)
//     run_req     in   pulse: release the core from IDLE with current contents
//     in_valid    in   stream byte valid
//     in_data     in   stream byte
//     in_ready    out  loader accepts a byte this cycle (combinational)
//     addr        in   fetch address from the core PC
//     inst        out  instruction at addr (combinational)
//     core_hold   out  1 = core held in reset (registered)
//     load_err    out  sticky checksum failure, cleared by load_start/reset
//     busy        out  loader in LOAD or CHECK
// ----------------------------------------------------------------------------
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int DEPTH = PL_DEPTH,
   parameter int AW    = PL_AW,
   parameter int DW    = PL_DW
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load_start,
   input  logic          run_req,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   input  logic [AW-1:0] addr,
   output logic [DW-1:0] inst,
   output logic          core_hold,
   output logic          load_err,
   output logic          busy
);

   loader_state_t r_state;
   loader_state_t w_state_next;

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] w_wr_ptr_next;
   logic [DW-1:0] r_sum;
   logic [DW-1:0] w_sum_next;
   logic [DW-1:0] w_sum_plus_byte;
   logic          r_load_err;
   logic          w_load_err_next;
   logic          r_core_hold;

   logic          w_in_ready;
   logic          w_accept;
   logic          w_mem_we;

   // A load_start in the same cycle masks ready so a byte presented alongside
   // the restart is never consumed by the discarded load.
   assign w_in_ready = ((r_state == LOAD) || (r_state == CHECK)) && !load_start;
   assign w_accept   = in_valid && w_in_ready;

   // Running sum including the byte on the bus; wraps mod 2**DW by width.
   assign w_sum_plus_byte = r_sum + in_data;

   // ------------------------------------------------------------------------
   // Next-state / datapath control
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_wr_ptr_next   = r_wr_ptr;
      w_sum_next      = r_sum;
      w_load_err_next = r_load_err;
      w_mem_we        = 1'b0;

      if (load_start) begin
         w_state_next    = LOAD;
         w_wr_ptr_next   = '0;
         w_sum_next      = '0;
         w_load_err_next = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (run_req) begin
                  w_state_next = RUN;
               end
            end

            LOAD: begin
               if (w_accept) begin
                  w_mem_we      = 1'b1;
                  w_sum_next    = w_sum_plus_byte;
                  // Pointer wraps naturally; the last word hands over to CHECK.
                  w_wr_ptr_next = r_wr_ptr + AW'(1);
                  if (r_wr_ptr == AW'(DEPTH - 1)) begin
                     w_state_next = CHECK;
                  end
               end
            end

            CHECK: begin
               if (w_accept) begin
                  if (w_sum_plus_byte == '0) begin
                     w_state_next = RUN;
                  end else begin
                     w_state_next    = ERR;
                     w_load_err_next = 1'b1;
                  end
               end
            end

            RUN: begin
               // Only load_start (handled above) or reset leaves RUN.
            end

            ERR: begin
               // run_req is deliberately ignored here.
            end

            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // State and control registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (resetn) begin
         r_state     <= IDLE;
         r_wr_ptr    <= '0;
         r_sum       <= '0;
         r_load_err  <= 1'b0;
         r_core_hold <= 1'b1;
      end else begin
         r_state     <= w_state_next;
         r_wr_ptr    <= w_wr_ptr_next;
         r_sum       <= w_sum_next;
         r_load_err  <= w_load_err_next;
         // Decoded from the next state so hold drops on the very edge that
         // enters RUN and rises on the edge that leaves it.
         r_core_hold <= (w_state_next != RUN);
      end
   end

   // ------------------------------------------------------------------------
   // Program storage
   // ------------------------------------------------------------------------
   prog_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_prog_ram (
      .clk     (clk),
      .resetn  (resetn),
      .i_we    (w_mem_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_data),
      .i_raddr (addr),
      .o_rdata (inst)
   );

   assign in_ready  = w_in_ready;
   assign core_hold = r_core_hold;
   assign load_err  = r_load_err;
   assign busy      = (r_state == LOAD) || (r_state == CHECK);

endmodule : prog_loader

// File: tb/tb_prog_loader.sv
// ----------------------------------------------------------------------------
// tb_prog_loader
//   Directed bench for prog_loader. Stimulus pushes expected output values
//   into chk_q and expected accepted bytes into acc_q; two monitors on the
//   falling edge pop and compare against what the DUT presents.
// ----------------------------------------------------------------------------
module tb_prog_loader;

   logic       clk = 1'b0;
   logic       resetn;
   logic       load_start;
   logic       run_req;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic [3:0] addr;
   logic [7:0] inst;
   logic       core_hold;
   logic       load_err;
   logic       busy;

   always #5 clk = ~clk;

   prog_loader dut (
      .clk        (clk),
      .resetn     (resetn),
      .load_start (load_start),
      .run_req    (run_req),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .addr       (addr),
      .inst       (inst),
      .core_hold  (core_hold),
      .load_err   (load_err),
      .busy       (busy)
   );

   localparam int SIG_INST = 0;
   localparam int SIG_HOLD = 1;
   localparam int SIG_ERR  = 2;
   localparam int SIG_RDY  = 3;
   localparam int SIG_BUSY = 4;

   typedef struct {
      int         sig;
      logic [7:0] exp;
      string      name;
   } chk_t;

   chk_t       chk_q[$];
   logic [7:0] acc_q[$];

   int errors    = 0;
   int checks    = 0;
   int accepts   = 0;
   int cyc_count = 0;

   logic [7:0] img_a [16];   // 01..10, sum 88, good checksum 78
   logic [7:0] img_b [16];   // 10..01, sum 88, good checksum 78
   logic [7:0] img_z [16];   // all zero (cleared store)

   function automatic void do_check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic logic [7:0] dut_sig(int s);
      logic [7:0] v;
      v = 8'hxx;
      case (s)
         SIG_INST: v = inst;
         SIG_HOLD: v = {7'd0, core_hold};
         SIG_ERR:  v = {7'd0, load_err};
         SIG_RDY:  v = {7'd0, in_ready};
         SIG_BUSY: v = {7'd0, busy};
         default:  v = 8'hxx;
      endcase
      return v;
   endfunction

   task automatic expect_sig(int s, logic [7:0] e, string n);
      chk_t c;
      c.sig  = s;
      c.exp  = e;
      c.name = n;
      chk_q.push_back(c);
   endtask

   // Output monitor: every expectation queued since the last falling edge is
   // compared against the DUT outputs as they stand mid-cycle.
   always @(negedge clk) begin
      chk_t c;
      while (chk_q.size() > 0) begin
         c = chk_q.pop_front();
         do_check(c.name, {24'd0, dut_sig(c.sig)}, {24'd0, c.exp});
      end
   end

   // Handshake monitor: each byte the DUT takes must be the next one the
   // stimulus intended to deliver.
   always @(negedge clk) begin
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         accepts++;
         if (acc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got byte %0h accepted, expected no accept", in_data);
         end else begin
            do_check("accept_byte", {24'd0, in_data}, {24'd0, acc_q.pop_front()});
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit hs;
      bit done;
      if (gaps) begin
         for (int g = 0; g < 3; g++) begin
            if ($urandom_range(0, 1) == 0) break;
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            tick();
            cyc_count++;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      acc_q.push_back(b);
      done = 1'b0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clk);
         hs = in_ready;
         tick();
         cyc_count++;
         if (hs) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL handshake_timeout: got no accept in 20 cycles, expected accept of %0h", b);
      end
   endtask

   task automatic stream(input logic [7:0] img [16], input logic [7:0] ck,
                         input bit gaps, input bit with_ck);
      for (int i = 0; i < 16; i++) begin
         send_byte(img[i], gaps);
      end
      if (with_ck) begin
         send_byte(ck, gaps);
      end
      in_valid = 1'b0;
   endtask

   task automatic pulse_load(string tag);
      load_start = 1'b1;
      expect_sig(SIG_RDY, 8'd0, {tag, "_ready_masked"});
      tick();
      load_start = 1'b0;
      expect_sig(SIG_BUSY, 8'd1, {tag, "_busy_after_start"});
      expect_sig(SIG_HOLD, 8'd1, {tag, "_hold_after_start"});
      expect_sig(SIG_ERR,  8'd0, {tag, "_err_cleared"});
   endtask

   task automatic check_all_inst(input logic [7:0] img [16], string tag);
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a);
         expect_sig(SIG_INST, img[a], $sformatf("%s_inst_%0d", tag, a));
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         img_a[i] = 8'(i + 1);
         img_b[i] = 8'(16 - i);
         img_z[i] = 8'h00;
      end
      resetn     = 1'b1;
      load_start = 1'b0;
      run_req    = 1'b0;
      in_valid   = 1'b0;
      in_data    = 8'h00;
      addr       = 4'h0;

      // Reset state
      tick();
      tick();
      resetn = 1'b0;
      expect_sig(SIG_HOLD, 8'd1, "reset_hold");
      expect_sig(SIG_RDY,  8'd0, "reset_ready");
      expect_sig(SIG_ERR,  8'd0, "reset_err");
      expect_sig(SIG_BUSY, 8'd0, "reset_busy");
      check_all_inst(img_z, "reset");

      // Good load with valid held high: 17 accepts in 17 cycles
      pulse_load("good");
      cyc_count = 0;
      stream(img_a, 8'h78, 1'b0, 1'b1);
      do_check("burst_cycles", cyc_count, 17);
      expect_sig(SIG_HOLD, 8'd0, "good_hold");
      expect_sig(SIG_ERR,  8'd0, "good_err");
      expect_sig(SIG_BUSY, 8'd0, "good_busy");
      expect_sig(SIG_RDY,  8'd0, "good_ready");
      addr = 4'hA;
      expect_sig(SIG_INST, 8'h0B, "good_inst_A");
      tick();
      check_all_inst(img_a, "good");

      // Bad checksum -> ERR, run_req ignored
      pulse_load("bad");
      stream(img_a, 8'h77, 1'b0, 1'b1);
      expect_sig(SIG_ERR,  8'd1, "bad_err");
      expect_sig(SIG_HOLD, 8'd1, "bad_hold");
      expect_sig(SIG_BUSY, 8'd0, "bad_busy");
      tick();
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      expect_sig(SIG_HOLD, 8'd1, "bad_runreq_hold");
      expect_sig(SIG_ERR,  8'd1, "bad_runreq_err");
      tick();
      expect_sig(SIG_HOLD, 8'd1, "bad_runreq_hold2");
      tick();

      // Restart after 5 bytes with a byte offered in the restart cycle
      pulse_load("rst5");
      for (int i = 0; i < 5; i++) begin
         send_byte(8'(8'hA0 + i), 1'b0);
      end
      load_start = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'hEE;
      expect_sig(SIG_RDY, 8'd0, "restart_ready_masked");
      tick();
      load_start = 1'b0;
      in_valid   = 1'b0;
      addr       = 4'h0;
      expect_sig(SIG_INST, 8'hA0, "restart_keeps_word0");
      expect_sig(SIG_BUSY, 8'd1,  "restart_busy");
      tick();
      addr = 4'h5;
      expect_sig(SIG_INST, 8'h06, "restart_word5_old");
      tick();
      stream(img_b, 8'h78, 1'b0, 1'b1);
      expect_sig(SIG_HOLD, 8'd0, "restart_hold");
      expect_sig(SIG_ERR,  8'd0, "restart_err");
      check_all_inst(img_b, "restart");

      // Valid load with random gaps on in_valid
      pulse_load("gap");
      stream(img_a, 8'h78, 1'b1, 1'b1);
      expect_sig(SIG_HOLD, 8'd0, "gap_hold");
      expect_sig(SIG_ERR,  8'd0, "gap_err");
      expect_sig(SIG_BUSY, 8'd0, "gap_busy");
      check_all_inst(img_a, "gap");

      // Reset while in CHECK, then run the cleared store
      pulse_load("rchk");
      stream(img_a, 8'h00, 1'b0, 1'b0);
      expect_sig(SIG_BUSY, 8'd1, "check_busy");
      expect_sig(SIG_RDY,  8'd1, "check_ready");
      expect_sig(SIG_HOLD, 8'd1, "check_hold");
      tick();
      resetn = 1'b1;
      tick();
      resetn = 1'b0;
      expect_sig(SIG_HOLD, 8'd1, "rchk_hold");
      expect_sig(SIG_BUSY, 8'd0, "rchk_busy");
      expect_sig(SIG_RDY,  8'd0, "rchk_ready");
      expect_sig(SIG_ERR,  8'd0, "rchk_err");
      check_all_inst(img_z, "rchk");
      run_req = 1'b1;
      tick();
      run_req = 1'b0;
      expect_sig(SIG_HOLD, 8'd0, "zrun_hold");
      expect_sig(SIG_BUSY, 8'd0, "zrun_busy");
      check_all_inst(img_z, "zrun");

      tick();
      tick();
      do_check("acc_q_drained", acc_q.size(), 0);
      do_check("chk_q_drained", chk_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_prog_loader
